// File: rtl/serial_xfer_ctrl.sv
// Sequencer for a WIDTH-bit serial shift datapath. Each transfer loads a parallel
// word, shifts it out LSB-first on so while capturing si, then pulses done with the received word.
module serial_xfer_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             si,
  output logic             so,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [CNTW-1:0]  cnt;

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_reg   <= '0;
      rx_reg   <= '0;
      cnt      <= '0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_reg   <= din;
            cnt      <= '0;
            state    <= SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          tx_reg <= {1'b0, tx_reg[WIDTH-1:1]};
          rx_reg <= {si, rx_reg[WIDTH-1:1]};
          if (cnt == LAST) begin
            state    <= DONE;
            shift_en <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          shift_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // tx_reg has shifted out to all zeros by the end of SHIFT and is only reloaded
  // on entry to SHIFT, so its LSB is already 0 outside SHIFT.
  assign so   = tx_reg[0];
  assign dout = rx_reg;

endmodule
